// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one serial TX line between two byte requesters (0 = CPU UART,
//   1 = debug/trace). It grants round-robin per byte, captures the granted
//   byte and shifts it out as 8N1, or as 8E1 when UART_TX_ARB_PARITY_EN is
//   defined, at CLKDIV clocks per bit.
//
//   Macro: UART_TX_ARB_PARITY_EN adds an even-parity bit after bit 7.
//
//   Ports
//     clk, resetn            clock, async active-low reset
//     tx_en                  gates new accepts only (frame in flight completes)
//     reqN_valid/data/ready  byte request; ready is a 1-cycle accept pulse
//     ser_tx                 serial line, idle high, straight from a flop
//     busy                   accept cycle through last stop-bit cycle
//     last_grant             index of the most recently accepted requester
module uart_tx_arbiter #(
  parameter int unsigned CLKDIV = 106
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tx_en,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       ser_tx,
  output logic       busy,
  output logic       last_grant
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_ARB_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      state;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;
  logic [15:0] div_cnt;
  logic        prio;
`ifdef UART_TX_ARB_PARITY_EN
  logic        par;
`endif

  logic can_acc, gnt1, gnt0, accept, div_last;

  // Ready is a combinational function of the IDLE state so the accept
  // happens in the same cycle the requester presents valid. It is also
  // gated by resetn so a held valid cannot see ready while reset is asserted.
  always_comb begin
    can_acc    = resetn & (state == IDLE) & tx_en;
    gnt1       = req1_valid & (~req0_valid | prio);
    gnt0       = req0_valid & ~gnt1;
    req0_ready = can_acc & gnt0;
    req1_ready = can_acc & gnt1;
    accept     = req0_ready | req1_ready;
    busy       = (state != IDLE) | accept;
    div_last   = (div_cnt == 16'(CLKDIV - 1));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      ser_tx     <= 1'b1;
      shreg      <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      prio       <= 1'b0;
      last_grant <= 1'b0;
`ifdef UART_TX_ARB_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ser_tx  <= 1'b1;
          div_cnt <= '0;
          if (accept) begin
            shreg      <= gnt1 ? req1_data : req0_data;
            last_grant <= gnt1;
            prio       <= ~gnt1;
`ifdef UART_TX_ARB_PARITY_EN
            par        <= gnt1 ? ^req1_data : ^req0_data;
`endif
            ser_tx     <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (div_last) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            ser_tx  <= shreg[0];
            state   <= DATA;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        DATA: begin
          if (div_last) begin
            div_cnt <= '0;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_ARB_PARITY_EN
              ser_tx <= par;
              state  <= PARITY;
`else
              ser_tx <= 1'b1;
              state  <= STOP;
`endif
            end else begin
              // line always shows shreg[0]; shift so the next bit is at [0]
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= shreg >> 1;
              ser_tx  <= shreg[1];
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
`ifdef UART_TX_ARB_PARITY_EN
        PARITY: begin
          if (div_last) begin
            div_cnt <= '0;
            ser_tx  <= 1'b1;
            state   <= STOP;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
`endif
        STOP: begin
          if (div_last) begin
            div_cnt <= '0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        default: begin
          state  <= IDLE;
          ser_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: line-level reference model (queue of
// expected ser_tx levels) checked every cycle, a vector table of single
// transfers, and directed sequences for contention, tx_en gating and reset.
module tb_uart_tx_arbiter;
`ifdef UART_TX_ARB_PARITY_EN
  localparam int C  = 4;
  localparam int NB = 11;
`else
  localparam int C  = 106;
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       tx_en = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic       r0, r1, ser, busy, lg;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.CLKDIV(C)) dut (
    .clk(clk), .resetn(resetn), .tx_en(tx_en),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
    .ser_tx(ser), .busy(busy), .last_grant(lg)
  );

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // lq holds the expected line level for each cycle after an accept; an
  // empty queue means the transmitter is idle and may accept this cycle.
  bit lq[$];
  bit mprio = 1'b0, mlast = 1'b0;

  always @(negedge clk) begin : model
    bit idle, acc, who;
    logic [7:0] b;
    if (!resetn) begin
      lq.delete();
      mprio = 1'b0;
      mlast = 1'b0;
      chk("rst_ser", ser, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rdy0", r0, 0);
      chk("rst_rdy1", r1, 0);
      chk("rst_lg", lg, 0);
    end else begin
      idle = (lq.size() == 0);
      chk("m_ser", ser, idle ? 1'b1 : lq[0]);
      if (!idle) void'(lq.pop_front());
      acc = idle && tx_en && (v0 || v1);
      who = (v0 && v1) ? mprio : v1;
      chk("m_rdy0", r0, acc && !who);
      chk("m_rdy1", r1, acc && who);
      chk("m_busy", busy, !idle || acc);
      chk("m_lg", lg, mlast);
      if (acc) begin
        b = who ? d1 : d0;
        repeat (C) lq.push_back(1'b0);
        for (int k = 0; k < 8; k++) repeat (C) lq.push_back(b[k]);
`ifdef UART_TX_ARB_PARITY_EN
        repeat (C) lq.push_back(^b);
`endif
        repeat (C) lq.push_back(1'b1);
        mlast = who;
        mprio = !who;
      end
    end
  end

  // ---------------- helpers ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < NB * C + 20 && busy; i++) @(negedge clk);
    chk("idle_timeout", busy, 0);
    tick();
  endtask

  typedef struct {
    logic       v0, v1;
    logic [7:0] d0, d1;
    logic       exp_port;
    logic [7:0] exp_byte;
  } vec_t;
  vec_t vecs[8];

  // Presents one request, waits for the accept, then decodes the frame at
  // bit centres and measures how long busy stays high.
  task automatic run_vec(input vec_t v);
    bit got, port;
    int bc;
    logic [15:0] bits;
    v0 = v.v0; v1 = v.v1; d0 = v.d0; d1 = v.d1; tx_en = 1'b1;
    got = 0; port = 0; bits = '0;
    for (int i = 0; i < 2 * NB * C + 10 && !got; i++) begin
      @(negedge clk);
      if (r0 || r1) begin got = 1; port = r1; end
    end
    if (!got) begin
      chk("vec_accept_timeout", 0, 1);
      v0 = 0; v1 = 0;
      tick();
      return;
    end
    chk("vec_port", port, v.exp_port);
    bc = 1;
    @(posedge clk); #1;
    v0 = 0; v1 = 0;
    for (int n = 1; n < NB * C + 20; n++) begin
      @(negedge clk);
      if (busy) bc++;
      if ((n - 1) % C == C / 2 && (n - 1) / C < NB) bits[(n - 1) / C] = ser;
    end
    chk("vec_start", bits[0], 0);
    chk("vec_byte", bits[8:1], v.exp_byte);
`ifdef UART_TX_ARB_PARITY_EN
    chk("vec_parity", bits[9], ^v.exp_byte);
`endif
    chk("vec_stop", bits[NB-1], 1);
    chk("vec_busy_len", bc, NB * C + 1);
    tick();
  endtask

  task automatic do_reset;
    resetn = 0;
    repeat (2) tick();
    resetn = 1;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int acc_cyc[4];
    bit acc_port[4];
    int na;
    bit a0, a1;

    vecs[0] = '{1, 0, 8'h41, 8'h00, 0, 8'h41};
    vecs[1] = '{1, 1, 8'h30, 8'h31, 1, 8'h31};
    vecs[2] = '{1, 1, 8'h30, 8'h31, 0, 8'h30};
    vecs[3] = '{1, 1, 8'h30, 8'h31, 1, 8'h31};
    vecs[4] = '{0, 1, 8'h00, 8'h7E, 1, 8'h7E};
    vecs[5] = '{0, 1, 8'h00, 8'hA5, 1, 8'hA5};
    vecs[6] = '{1, 1, 8'h00, 8'hFF, 0, 8'h00};
    vecs[7] = '{1, 0, 8'hFF, 8'h00, 0, 8'hFF};

    // reset state, with requests pending to show ready stays low
    resetn = 0; v0 = 1; v1 = 1; tx_en = 1;
    repeat (3) tick();
    chk("reset_ser", ser, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rdy", {r0, r1}, 0);
    chk("reset_lg", lg, 0);
    v0 = 0; v1 = 0;
    resetn = 1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // contention: both valid continuously from reset, alternate grants
    do_reset();
    v0 = 1; v1 = 1; d0 = 8'h30; d1 = 8'h31;
    na = 0;
    for (int i = 0; i < 4 * (NB * C + 1) + 20 && na < 4; i++) begin
      @(negedge clk);
      if (r0 || r1) begin acc_cyc[na] = cyc; acc_port[na] = r1; na++; end
    end
    chk("cont_count", na, 4);
    for (int i = 0; i < na; i++) chk("cont_order", acc_port[i], i % 2);
    for (int i = 1; i < na; i++) chk("cont_spacing", acc_cyc[i] - acc_cyc[i-1], NB * C + 1);
    tick();
    v0 = 0; v1 = 0;
    wait_idle();

    // tx_en gating: drop mid-frame, keep a request pending
    v0 = 1; d0 = 8'h55;
    na = 0;
    for (int i = 0; i < 10 && na == 0; i++) begin
      @(negedge clk);
      if (r0) na = 1;
    end
    chk("txen_first_accept", na, 1);
    tick();
    repeat (3 * C) tick();
    tx_en = 0;
    wait_idle();
    for (int i = 0; i < 2 * C; i++) begin
      @(negedge clk);
      chk("txen_no_ready", r0 | r1, 0);
    end
    tick();
    tx_en = 1;
    @(negedge clk);
    chk("txen_resume_ready", r0, 1);
    tick();
    v0 = 0;
    wait_idle();

    // reset during data bit 3
    v0 = 1; d0 = 8'h55;
    @(negedge clk);
    chk("rmf_accept", r0, 1);
    tick();
    v0 = 0;
    repeat (4 * C + C / 2) tick();
    v0 = 1; v1 = 1; d1 = 8'h7E;
    resetn = 0;
    #1;
    chk("rmf_ser", ser, 1);
    chk("rmf_busy", busy, 0);
    chk("rmf_rdy", {r0, r1}, 0);
    repeat (2) tick();
    v0 = 0; v1 = 0;
    resetn = 1;
    tick();
    run_vec('{0, 1, 8'h00, 8'h7E, 1, 8'h7E});
    chk("rmf_last_grant", lg, 1);

    // randomized traffic, checked by the line model
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      a0 = r0; a1 = r1;
      @(posedge clk); #1;
      if (a0) v0 = 0;
      else if (v0 && $urandom_range(199) == 0) v0 = 0;
      else if (!v0 && $urandom_range(39) == 0) begin v0 = 1; d0 = 8'($urandom); end
      if (a1) v1 = 0;
      else if (v1 && $urandom_range(199) == 0) v1 = 0;
      else if (!v1 && $urandom_range(39) == 0) begin v1 = 1; d1 = 8'($urandom); end
      if ($urandom_range(499) == 0) tx_en = !tx_en;
    end
    tick();
    v0 = 0; v1 = 0; tx_en = 1;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Serial transmit controller for PicoSoC that shares the single `ser_tx` line between two byte-stream requesters: port 0 is the CPU UART path and port 1 is the debug/trace path. It arbitrates round-robin per byte, captures the granted byte, and serializes it as 8N1 with a fixed clock divider. It sits between the SoC bus-side UART logic and the top-level `ser_tx` pin.

## Interface
Parameters:
- `CLKDIV`, default 106: clock cycles per serial bit. The legal range is 2..65535. The default matches a half-bit sampling interval of 53 cycles.

Ports:
- `clk`  input  1  system clock; all logic is on the rising edge.
- `resetn`  input  1  reset, asynchronous assert, active low.
- `tx_en`  input  1  when low, no new byte is accepted; a frame already in flight completes.
- `req0_valid`  input  1  requester 0 has a byte.
- `req0_data`  input  8  requester 0 byte. Must be stable while `req0_valid` is high.
- `req0_ready`  output  1  one-cycle accept pulse for requester 0.
- `req1_valid`  input  1  requester 1 has a byte.
- `req1_data`  input  8  requester 1 byte. Same stability rule as port 0.
- `req1_ready`  output  1  one-cycle accept pulse for requester 1.
- `ser_tx`  output  1  serial line; idle level is high.
- `busy`  output  1  high from the accept cycle through the last stop-bit cycle.
- `last_grant`  output  1  index of the requester most recently accepted.

## Operation
- States:
  - IDLE → START → DATA → STOP → IDLE.
  - With `UART_TX_ARB_PARITY_EN` defined: IDLE → START → DATA → PARITY → STOP → IDLE.
- IDLE:
  - If `tx_en` is high and any valid is high, the arbiter picks one requester.
  - It asserts that requester's ready for exactly one cycle.
  - It loads the shift register from that requester's data and moves to START.
- Round-robin selection:
  - `prio` names the preferred requester.
  - If only one requester is valid, it wins.
  - If both are valid, `prio` wins.
  - After a grant to N, `prio` becomes 1−N.
- Handshake: a transfer occurs in the cycle where valid and ready are both high. Ready is never high outside IDLE. Requester data is ignored after the accept cycle.
- Line levels per state:
  - START drives 0.
  - DATA drives the shift register, LSB first, for 8 bits.
  - STOP drives 1.
- Bit counter: 3 bits wide, counts 0..7 and exits DATA after bit 7.
- Divider counter: 16 bits wide, counts 0..CLKDIV−1. It is cleared on every state or bit change.
- Valid dropped before accept: the request is simply withdrawn and nothing is sent.
- `tx_en` dropping mid-frame has no effect on the current frame.
- Reset, including mid-frame:
  - Reset values: `ser_tx`=1, `busy`=0, `req0_ready`=0, `req1_ready`=0, `last_grant`=0, `prio`=0, state IDLE.
  - The partial frame is abandoned and the line returns high immediately.

## Timing
- Accept happens in cycle A, where ready=1 and busy rises at the A edge.
- The START bit drives `ser_tx` low from cycle A+1 for CLKDIV cycles.
- Data bit k occupies cycles A+1+(k+1)·CLKDIV through A+(k+2)·CLKDIV.
- STOP lasts CLKDIV cycles. `busy` falls after the last STOP cycle.
- One IDLE cycle always separates frames.
- Back-to-back frame period is 10·CLKDIV+1 cycles (11·CLKDIV+1 with parity).
- `ser_tx` is driven directly from a flop, so there are no glitches.

## Configuration
- `UART_TX_ARB_PARITY_EN` defined:
  - A PARITY state between DATA and STOP drives the even-parity bit (XOR of the 8 data bits) for CLKDIV cycles.
  - The frame is 8E1, 11 bits.
- Not defined: frame is 8N1, 10 bits, and the PARITY state and logic are absent.

## Test plan
- Single byte, CLKDIV=106, macro undefined: req0 sends 0x41.
  - `req0_ready` pulses once.
  - `ser_tx` is low 106 cycles, then bits 1,0,0,0,0,0,1,0 at 106 cycles each, then high.
  - Monitor decodes 'A'.
  - `busy` is high for 1061 cycles.
- Contention: both valid continuously, req0=0x30, req1=0x31.
  - Accept order is 0,1,0,1.
  - Monitor sees '0','1','0','1'.
  - Accepts are spaced 1061 cycles apart.
- `tx_en` gating: drop `tx_en` during a frame of 0x55.
  - The frame completes intact.
  - No new ready occurs while `tx_en` is low.
  - The next byte is accepted one cycle after `tx_en` rises.
- Reset mid-frame: assert `resetn`=0 during data bit 3.
  - `ser_tx`=1, `busy`=0, and both readies are 0 immediately.
  - After release, req1=0x7E is sent cleanly.
  - `last_grant`=1.
- Parity build, CLKDIV=4: send 0x07.
  - The bit after bit 7 is 1 (three ones gives parity 1).
  - The frame spans 44 cycles, and `busy` is high for 45 cycles.
